rpn_stack_calculator: RTL and testbench

//   Parametrised successor of the board calculator core: a reverse-Polish stack machine.

---
 rtl/rpn_stack_calculator.sv | 162 ++++++++++++++++
 tb/tb_rpn_stack_calculator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calculator.sv
// Reverse-Polish stack calculator core: push/drop/add/subtract/multiply on a
// small LIFO, with an optional iterative shift-add multiplier.
module rpn_stack_calculator #(
  parameter int DATA_WIDTH    = 8,
  parameter int RESULT_WIDTH  = 16,
  parameter int STACK_DEPTH   = 4,
  parameter int MUL_ITERATIVE = 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enter,
  input  logic                               add,
  input  logic                               subtract,
  input  logic                               multiply,
  input  logic                               drop,
  input  logic [DATA_WIDTH-1:0]              data,
  output logic [RESULT_WIDTH-1:0]            result,
  output logic                               overflow,
  output logic [3:0]                         error,
  output logic                               busy,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int CW = $clog2(RESULT_WIDTH + 1);
  localparam int PW = 2 * RESULT_WIDTH;

  typedef enum logic {IDLE, MUL} state_t;

  state_t                  state;
  state_t                  state_next;

  logic [RESULT_WIDTH-1:0] stack [STACK_DEPTH];
  logic [IW-1:0]           tos_idx;
  logic [IW-1:0]           nos_idx;
  logic [RESULT_WIDTH-1:0] tos;
  logic [RESULT_WIDTH-1:0] nos;

  logic [4:0]              cmds;
  logic                    one_hot;
  logic                    any_cmd;
  logic                    full;
  logic                    two_or_more;

  logic [RESULT_WIDTH:0]   sum;
  logic [RESULT_WIDTH:0]   diff;
  logic [PW-1:0]           product;

  logic [PW-1:0]           acc;
  logic [PW-1:0]           mcand;
  logic [RESULT_WIDTH-1:0] mplier;
  logic [CW-1:0]           count;
  logic [PW-1:0]           acc_step;

  assign cmds        = {enter, add, subtract, multiply, drop};
  assign one_hot     = $onehot(cmds);
  assign any_cmd     = |cmds;
  assign full        = (depth == DW'(STACK_DEPTH));
  assign two_or_more = (depth >= DW'(2));

  assign tos_idx = IW'(depth - DW'(1));
  assign nos_idx = IW'(depth - DW'(2));
  assign tos     = stack[tos_idx];
  assign nos     = stack[nos_idx];

  assign sum      = {1'b0, nos} + {1'b0, tos};
  assign diff     = {1'b0, nos} - {1'b0, tos};
  assign product  = PW'(nos) * PW'(tos);
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  assign result = (depth == '0) ? '0 : tos;
  assign busy   = (state == MUL);

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state: leave IDLE only for an accepted iterative multiply
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (MUL_ITERATIVE != 0 && one_hot && multiply && two_or_more)
              state_next = MUL;
      MUL:  if (count == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stack, status and multiplier datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
      depth    <= '0;
      overflow <= 1'b0;
      error    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
    end else if (state == MUL) begin
      if (any_cmd) error <= 4'd3;
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      // The final step's sum is written straight to the stack so the product
      // lands on the same edge the FSM returns to IDLE.
      if (count == CW'(1)) begin
        stack[nos_idx] <= acc_step[RESULT_WIDTH-1:0];
        overflow       <= |acc_step[PW-1:RESULT_WIDTH];
        depth          <= depth - DW'(1);
      end
    end else if (any_cmd) begin
      if (!one_hot) begin
        error <= 4'd3;
      end else if (enter) begin
        if (full) begin
          error <= 4'd2;
        end else begin
          stack[IW'(depth)] <= RESULT_WIDTH'(data);
          depth             <= depth + DW'(1);
          overflow          <= 1'b0;
          error             <= '0;
        end
      end else if (drop) begin
        if (depth == '0) begin
          error <= 4'd1;
        end else begin
          depth    <= depth - DW'(1);
          overflow <= 1'b0;
          error    <= '0;
        end
      end else if (!two_or_more) begin
        error <= 4'd1;
      end else begin
        error <= '0;
        if (add) begin
          stack[nos_idx] <= sum[RESULT_WIDTH-1:0];
          overflow       <= sum[RESULT_WIDTH];
          depth          <= depth - DW'(1);
        end else if (subtract) begin
          stack[nos_idx] <= diff[RESULT_WIDTH-1:0];
          overflow       <= diff[RESULT_WIDTH];
          depth          <= depth - DW'(1);
        end else if (MUL_ITERATIVE != 0) begin
          acc    <= '0;
          mcand  <= PW'(nos);
          mplier <= tos;
          count  <= CW'(RESULT_WIDTH);
        end else begin
          stack[nos_idx] <= product[RESULT_WIDTH-1:0];
          overflow       <= |product[PW-1:RESULT_WIDTH];
          depth          <= depth - DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Randomized bench for rpn_stack_calculator against a queue-based RPN model,
// plus directed checks of a single-cycle-multiply instance.
module tb_rpn_stack_calculator;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_ENTER = 5'b10000;
  localparam logic [4:0] C_ADD   = 5'b01000;
  localparam logic [4:0] C_SUB   = 5'b00100;
  localparam logic [4:0] C_MUL   = 5'b00010;
  localparam logic [4:0] C_DROP  = 5'b00001;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enter, add, subtract, multiply, drop;
  logic [7:0]  data;
  logic [15:0] result;
  logic        overflow;
  logic [3:0]  error;
  logic        busy;
  logic [2:0]  depth;

  logic        f_enter, f_add, f_subtract, f_multiply, f_drop;
  logic [7:0]  f_data;
  logic [15:0] f_result;
  logic        f_overflow;
  logic [3:0]  f_error;
  logic        f_busy;
  logic [2:0]  f_depth;

  int n_vectors    = 0;
  int n_miscompares = 0;

  // model state
  int unsigned m_q[$];
  int unsigned m_ovf, m_err, m_left, m_prod, m_povf;

  always #5 clock = ~clock;

  rpn_stack_calculator dut (
    .clock(clock), .reset_n(reset_n), .enter(enter), .add(add),
    .subtract(subtract), .multiply(multiply), .drop(drop), .data(data),
    .result(result), .overflow(overflow), .error(error), .busy(busy),
    .depth(depth)
  );

  rpn_stack_calculator #(.MUL_ITERATIVE(0)) dut_fast (
    .clock(clock), .reset_n(reset_n), .enter(f_enter), .add(f_add),
    .subtract(f_subtract), .multiply(f_multiply), .drop(f_drop), .data(f_data),
    .result(f_result), .overflow(f_overflow), .error(f_error), .busy(f_busy),
    .depth(f_depth)
  );

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0; m_err = 0; m_left = 0; m_prod = 0; m_povf = 0;
  endtask

  // one rising edge of the RPN machine, in plain arithmetic
  task automatic model_edge(input logic [4:0] cmd, input logic [7:0] d);
    int unsigned tos, nos;
    longint unsigned p;
    if (m_left > 0) begin
      if (cmd != 0) m_err = 3;
      m_left--;
      if (m_left == 0) begin
        void'(m_q.pop_back()); void'(m_q.pop_back());
        m_q.push_back(m_prod);
        m_ovf = m_povf;
      end
    end else if ($countones(cmd) > 1) begin
      m_err = 3;
    end else if (cmd == C_ENTER) begin
      if (m_q.size() == 4) m_err = 2;
      else begin m_q.push_back(int'(d)); m_ovf = 0; m_err = 0; end
    end else if (cmd == C_DROP) begin
      if (m_q.size() == 0) m_err = 1;
      else begin void'(m_q.pop_back()); m_ovf = 0; m_err = 0; end
    end else if (cmd != C_NONE) begin
      if (m_q.size() < 2) m_err = 1;
      else begin
        tos = m_q[$];
        nos = m_q[$-1];
        m_err = 0;
        if (cmd == C_MUL) begin
          p = longint'(nos) * longint'(tos);
          m_prod = int'(p % 65536);
          m_povf = (p >= 65536) ? 1 : 0;
          m_left = 16;
        end else begin
          void'(m_q.pop_back()); void'(m_q.pop_back());
          if (cmd == C_ADD) begin
            m_q.push_back((nos + tos) % 65536);
            m_ovf = (nos + tos > 65535) ? 1 : 0;
          end else begin
            m_q.push_back((nos + 65536 - tos) % 65536);
            m_ovf = (nos < tos) ? 1 : 0;
          end
        end
      end
    end
  endtask

  task automatic check_main(input string tag);
    check({tag, ".result"},   result,   (m_q.size() == 0) ? 0 : m_q[$]);
    check({tag, ".depth"},    depth,    m_q.size());
    check({tag, ".overflow"}, overflow, m_ovf);
    check({tag, ".error"},    error,    m_err);
    check({tag, ".busy"},     busy,     (m_left > 0) ? 1 : 0);
  endtask

  task automatic step(input string tag, input logic [4:0] cmd, input logic [7:0] d);
    {enter, add, subtract, multiply, drop} = cmd;
    data = d;
    {f_enter, f_add, f_subtract, f_multiply, f_drop} = C_NONE;
    @(posedge clock);
    model_edge(cmd, d);
    #1;
    check_main(tag);
  endtask

  task automatic fstep(input logic [4:0] cmd, input logic [7:0] d,
                       input int unsigned e_res, input int unsigned e_depth,
                       input int unsigned e_ovf, input int unsigned e_err);
    {f_enter, f_add, f_subtract, f_multiply, f_drop} = cmd;
    f_data = d;
    {enter, add, subtract, multiply, drop} = C_NONE;
    @(posedge clock);
    model_edge(C_NONE, 8'h00);
    #1;
    check("fast.result",   f_result,   e_res);
    check("fast.depth",    f_depth,    e_depth);
    check("fast.overflow", f_overflow, e_ovf);
    check("fast.error",    f_error,    e_err);
    check("fast.busy",     f_busy,     0);
  endtask

  // asynchronous reset pulse, outputs checked before any clock edge
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 model_clear();
    check_main(tag);
    check("reset.fast_depth", f_depth, 0);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0] cmd;
    int unsigned r;
    reset_n = 1'b0;
    {enter, add, subtract, multiply, drop} = C_NONE;
    {f_enter, f_add, f_subtract, f_multiply, f_drop} = C_NONE;
    data = '0; f_data = '0;
    model_clear();
    #2;
    check_main("reset");
    #10 reset_n = 1'b1;

    // single-cycle multiply instance
    fstep(C_ENTER, 8'd3,   3,      1, 0, 0);
    fstep(C_ENTER, 8'd5,   5,      2, 0, 0);
    fstep(C_ADD,   8'd0,   8,      1, 0, 0);
    fstep(C_ENTER, 8'd5,   5,      2, 0, 0);
    fstep(C_MUL,   8'd0,   40,     1, 0, 0);
    fstep(C_ENTER, 8'hFF,  8'hFF,  2, 0, 0);
    fstep(C_ENTER, 8'hFF,  8'hFF,  3, 0, 0);
    fstep(C_MUL,   8'd0,   16'hFE01, 2, 0, 0);
    fstep(C_ENTER, 8'hFF,  8'hFF,  3, 0, 0);
    fstep(C_MUL,   8'd0,   16'h02FF, 2, 1, 0);

    // test 1
    do_reset("t1.reset");
    step("t1", C_ENTER, 8'd3);
    step("t1", C_ENTER, 8'd5);
    step("t1", C_ADD,   8'd0);
    check("t1.sum", result, 16'h0008);

    // test 2
    do_reset("t2.reset");
    step("t2", C_ENTER, 8'd3);
    step("t2", C_ENTER, 8'd5);
    step("t2", C_SUB,   8'd0);
    check("t2.diff", result, 16'hFFFE);
    check("t2.borrow", overflow, 1);

    // test 3
    do_reset("t3.reset");
    step("t3", C_ENTER, 8'hFF);
    step("t3", C_ENTER, 8'hFF);
    step("t3", C_MUL,   8'd0);
    for (int i = 0; i < 16; i++) step("t3.wait", C_NONE, 8'd0);
    check("t3.product", result, 16'hFE01);
    step("t3", C_ENTER, 8'hFF);
    step("t3", C_MUL,   8'd0);
    for (int i = 0; i < 16; i++) step("t3.wait2", C_NONE, 8'd0);
    check("t3.product2", result, 16'h02FF);
    check("t3.ovf2", overflow, 1);

    // test 4
    do_reset("t4.reset");
    step("t4", C_ENTER, 8'd7);
    step("t4", C_ADD,   8'd0);
    check("t4.underflow", error, 1);
    for (int i = 0; i < 3; i++) step("t4.fill", C_ENTER, 8'(i + 1));
    step("t4", C_ENTER, 8'h99);
    check("t4.full", error, 2);
    check("t4.full_result", result, 3);

    // test 5
    do_reset("t5.reset");
    step("t5", C_ENTER, 8'h12);
    step("t5", C_ENTER, 8'h34);
    step("t5", C_MUL,   8'd0);
    for (int i = 0; i < 4; i++) step("t5.wait", C_NONE, 8'd0);
    step("t5.busy_add", C_ADD, 8'd0);
    check("t5.busy_err", error, 3);
    for (int i = 0; i < 11; i++) step("t5.wait", C_NONE, 8'd0);
    check("t5.product", result, 16'h03A8);
    step("t5.collide", C_ENTER | C_ADD, 8'd9);
    check("t5.collide_err", error, 3);

    // test 6
    do_reset("t6.reset");
    step("t6", C_ENTER, 8'd20);
    step("t6", C_ENTER, 8'd30);
    step("t6", C_MUL,   8'd0);
    for (int i = 0; i < 7; i++) step("t6.wait", C_NONE, 8'd0);
    do_reset("t6.abort");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset("rand.reset");
      r = $urandom_range(0, 99);
      if      (r < 30) cmd = C_ENTER;
      else if (r < 42) cmd = C_ADD;
      else if (r < 54) cmd = C_SUB;
      else if (r < 66) cmd = C_MUL;
      else if (r < 78) cmd = C_DROP;
      else if (r < 88) cmd = C_NONE;
      else             cmd = 5'($urandom);
      step("rand", cmd, 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
